// File: rtl/dispense_pkg.sv
// Shared types and helpers for the dispenser pump arbiter.
package dispense_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        ABORT  = 3'd4
    } state_t;

    localparam int DEF_NCH = 2;
    localparam int MAX_NCH = 8;

    // Index of the set bit in a one-hot vector (0 if none set).
    function automatic logic [2:0] oh2idx(input logic [MAX_NCH-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NCH; i++)
            if (oh[i]) idx = idx | 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/dispense_arb_rr_arb.sv
// Combinational round-robin select: first requester at or after ptr wins.
module rr_arb #(
    parameter int NCH = 2,
    parameter int PW  = 1
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] win,
    output logic           valid
);

    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(ptr) + i) % NCH;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/dispense_arb.sv
// Shared pump/valve arbiter: round-robin grant, load, run, drip-settle, cup-removal abort.
// Optional RUN watchdog with sticky err when DISPENSE_WDOG_EN is defined.
module dispense_arb
    import dispense_pkg::*;
#(
    parameter int NCH         = DEF_NCH,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic           clk,
    input  logic           RESET,
    input  logic [NCH-1:0] req,
    input  logic           cup_ok,
    input  logic [NCH-1:0] done,
    output logic [NCH-1:0] grant,
    output logic [NCH-1:0] load,
    output logic [NCH-1:0] abort,
    output logic           pump_en,
    output logic           busy,
    output logic           err
);

    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int STW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    if (NCH < 2 || NCH > MAX_NCH || SETTLE_CYC < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("dispense_arb: illegal parameter value");
    end

    state_t         state, state_n;
    logic [NCH-1:0] grant_n;
    logic [NCH-1:0] arb_win;
    logic           arb_vld;
    logic [PW-1:0]  ptr, ptr_nx;
    logic [STW-1:0] st_cnt;
    logic [2:0]     win_idx;
    logic           done_hit;
    logic           wd_exp;

    rr_arb #(.NCH(NCH), .PW(PW)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .win   (arb_win),
        .valid (arb_vld)
    );

    assign win_idx  = oh2idx(MAX_NCH'(grant));
    assign done_hit = |(done & grant);
    assign ptr_nx   = (int'(win_idx) == NCH - 1) ? '0 : PW'(int'(win_idx) + 1);
    assign busy     = (state != IDLE);

`ifdef DISPENSE_WDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYC);
    logic [WDW-1:0] wd_cnt;
    logic           err_q;

    assign wd_exp = (wd_cnt == WDW'(TIMEOUT_CYC - 1));
    assign err    = err_q;

    // Counter is zero on the first RUN cycle, so expiry lands on RUN cycle TIMEOUT_CYC.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == RUN) ? wd_cnt + 1'b1 : '0;
            if (state == RUN && cup_ok && !done_hit && wd_exp) err_q <= 1'b1;
        end
    end
`else
    assign wd_exp = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!RESET) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        case (state)
            IDLE: begin
                if (cup_ok && arb_vld) begin
                    state_n = LOAD;
                    grant_n = arb_win;
                end
            end
            LOAD: state_n = RUN;
            RUN: begin
                // Cup removal beats completion, completion beats the watchdog.
                if (!cup_ok)       state_n = ABORT;
                else if (done_hit) state_n = SETTLE;
                else if (wd_exp)   state_n = ABORT;
            end
            SETTLE: begin
                if (st_cnt == '0) begin
                    state_n = IDLE;
                    grant_n = '0;
                end
            end
            ABORT:   state_n = SETTLE;
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            grant   <= '0;
            load    <= '0;
            abort   <= '0;
            pump_en <= 1'b0;
            ptr     <= '0;
            st_cnt  <= '0;
        end else begin
            grant   <= grant_n;
            load    <= (state_n == LOAD)  ? grant_n : '0;
            abort   <= (state_n == ABORT) ? grant_n : '0;
            pump_en <= (state_n == RUN);
            if ((state == RUN && state_n == SETTLE) || state == ABORT)
                ptr <= ptr_nx;
            if (state_n == SETTLE && state != SETTLE)
                st_cnt <= STW'(SETTLE_CYC - 1);
            else if (state == SETTLE)
                st_cnt <= st_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_dispense_arb.sv
// Lockstep check of dispense_arb against a cycle-level behavioural model, directed then random stimulus.
module tb_dispense_arb;

    localparam int NCH         = 3;
    localparam int SETTLE_CYC  = 5;
    localparam int TIMEOUT_CYC = 8;

    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_SETTLE = 3, P_ABORT = 4;

    logic           clk = 1'b0;
    logic           RESET;
    logic [NCH-1:0] req, done, grant, load, abort;
    logic           cup_ok, pump_en, busy, err;

    int checks   = 0;
    int failures = 0;

    // model state: phase, active channel (-1 none), rr pointer, settle left, RUN cycles seen
    int m_ph, m_ch, m_ptr, m_left, m_run;
    bit m_err;

    always #5 clk = ~clk;

    dispense_arb #(.NCH(NCH), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk     (clk),
        .RESET   (RESET),
        .req     (req),
        .cup_ok  (cup_ok),
        .done    (done),
        .grant   (grant),
        .load    (load),
        .abort   (abort),
        .pump_en (pump_en),
        .busy    (busy),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        if (!RESET) begin
            m_ph = P_IDLE; m_ch = -1; m_ptr = 0; m_err = 0; m_left = 0; m_run = 0;
            return;
        end
        case (m_ph)
            P_IDLE: if (cup_ok && req != '0) begin
                for (int k = 0; k < NCH; k++) begin
                    int c;
                    c = (m_ptr + k) % NCH;
                    if (req[c]) begin m_ch = c; break; end
                end
                m_ph = P_LOAD;
            end
            P_LOAD: begin m_ph = P_RUN; m_run = 0; end
            P_RUN: begin
                if (!cup_ok) m_ph = P_ABORT;
                else if (done[m_ch]) begin
                    m_ph = P_SETTLE; m_left = SETTLE_CYC; m_ptr = (m_ch + 1) % NCH;
                end
`ifdef DISPENSE_WDOG_EN
                else if (m_run == TIMEOUT_CYC - 1) begin m_ph = P_ABORT; m_err = 1; end
`endif
                else m_run++;
            end
            P_SETTLE: begin
                m_left--;
                if (m_left == 0) begin m_ph = P_IDLE; m_ch = -1; end
            end
            P_ABORT: begin
                m_ptr = (m_ch + 1) % NCH; m_ph = P_SETTLE; m_left = SETTLE_CYC;
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        logic [31:0] oh;
        oh = (m_ch >= 0) ? (32'd1 << m_ch) : 32'd0;
        chk("grant",   32'(grant),   oh);
        chk("load",    32'(load),    (m_ph == P_LOAD)  ? oh : 32'd0);
        chk("abort",   32'(abort),   (m_ph == P_ABORT) ? oh : 32'd0);
        chk("pump_en", 32'(pump_en), 32'(m_ph == P_RUN));
        chk("busy",    32'(busy),    32'(m_ph != P_IDLE));
        chk("err",     32'(err),     32'(m_err));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        RESET = 1'b0; req = '0; done = '0; cup_ok = 1'b1;
        tick(); tick();
        RESET = 1'b1;
    endtask

    initial begin
        int          sc;
        logic [31:0] got_order[$];
        logic [31:0] exp_rr[4];

        m_ph = P_IDLE; m_ch = -1; m_ptr = 0; m_left = 0; m_run = 0; m_err = 0;

        // reset state
        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_pump",  32'(pump_en), 0);

        // single request: latency, foreign done ignored, settle length
        req = 3'b001;
        tick();
        chk("lat_grant", 32'(grant), 1);
        chk("lat_load",  32'(load), 1);
        chk("lat_pump0", 32'(pump_en), 0);
        tick();
        chk("lat_pump1", 32'(pump_en), 1);
        req = '0;
        tick();
        done = 3'b010; tick();
        chk("foreign_done", 32'(pump_en), 1);
        done = 3'b001; tick();
        done = '0;
        sc = 0;
        for (int k = 0; k < SETTLE_CYC + 3; k++) begin
            if (busy) sc++;
            tick();
        end
        chk("settle_len", 32'(sc), SETTLE_CYC);

        // round robin with all channels requesting
        do_reset();
        req = '1;
        repeat (40) begin
            done = (m_ph == P_RUN && m_run == 2) ? NCH'(1 << m_ch) : '0;
            tick();
            if (load != '0) got_order.push_back(32'(load));
        end
        exp_rr = '{32'd1, 32'd2, 32'd4, 32'd1};
        chk("rr_cnt", 32'(got_order.size() >= 4), 1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr_%0d", k), (k < got_order.size()) ? got_order[k] : 32'd0, exp_rr[k]);
        done = '0;

        // cup removed together with done: abort path, no grants while cup absent
        do_reset();
        req = 3'b001;
        tick(); tick(); tick();
        cup_ok = 1'b0; done = 3'b001;
        tick();
        chk("cup_abort", 32'(abort), 1);
        chk("cup_pump",  32'(pump_en), 0);
        done = '0; req = 3'b011;
        repeat (SETTLE_CYC + 6) tick();
        chk("nocup_grant", 32'(grant), 0);
        cup_ok = 1'b1;
        tick();
        chk("cup_back_grant", 32'(grant), 2);

        // reset mid-RUN
        do_reset();
        req = 3'b010;
        tick(); tick(); tick();
        RESET = 1'b0;
        tick();
        chk("rst_mid_grant", 32'(grant), 0);
        chk("rst_mid_busy",  32'(busy), 0);
        RESET = 1'b1; req = 3'b011;
        tick();
        chk("rst_ptr0", 32'(grant), 1);
        req = '0;

`ifdef DISPENSE_WDOG_EN
        // watchdog: no done at all
        repeat (TIMEOUT_CYC + 2) tick();
        chk("wd_err", 32'(err), 1);
        repeat (SETTLE_CYC + 2) tick();
        chk("wd_sticky", 32'(err), 1);
`else
        repeat (4) tick();
        done = 3'b001; tick(); done = '0;
        repeat (SETTLE_CYC + 2) tick();
`endif

        // randomized traffic with occasional cup removal and reset
        repeat (3000) begin
            RESET  = ($urandom_range(0, 499) != 0);
            cup_ok = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 3) == 0) req = NCH'($urandom);
            done = '0;
            if (m_ph == P_RUN && $urandom_range(0, 9) == 0) done[m_ch] = 1'b1;
            if ($urandom_range(0, 19) == 0) done = done | NCH'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
